writeback_arbiter: RTL
======================

// Module: writeback_arbiter
// PURPOSE
//  Writeback stage that feeds the single write port of the 32x32 register file.
//  It merges two result sources onto that port:
//   - in-order pipeline results, which always have priority;
//   - out-of-order multiply/divide results, which are buffered in a FIFO and
//     written only when the pipeline is not writing.
//  It keeps a per-register busy scoreboard so decode can stall on operands whose multdiv result is still pending.
// PARAMETERS
//  DEPTH  4  multdiv result FIFO entries; must be a power of 2, >= 2
//  CNT_W  3  width of q_count; equals log2(DEPTH)+1
// PORTS
//  clock             in   1      rising-edge clock
//  ctrl_reset_n      in   1      asynchronous, active-low reset
//  wb_valid          in   1      pipeline result valid this cycle; never stalled
//  wb_reg            in   5      pipeline destination register
//  wb_data           in   32     pipeline result
//  md_issue_valid    in   1      multdiv op issued this cycle
//  md_issue_reg      in   5      destination register of the issued multdiv op
//  md_valid          in   1      multdiv result offered
//  md_reg            in   5      multdiv result destination register
//  md_data           in   32     multdiv result
//  md_ready          out  1      FIFO can accept; result transfers when md_valid & md_ready
//  ctrl_writeEnable  out  1      register file write enable (registered)
//  ctrl_writeReg     out  5      register file write address (registered)
//  data_writeReg     out  32     register file write data (registered)
//  busy              out  32     scoreboard; bit r=1 means a multdiv result for r is pending
//  q_count           out  CNT_W  FIFO occupancy, 0..DEPTH
//  err_flag          out  1      sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all outputs 0 except md_ready=1;
//   - FIFO flushed, pointers 0, busy=0, err_flag=0;
//   - reset asserted mid-operation discards queued results; nothing is written.
//  Write port selection, evaluated each cycle, result registered at the next posedge:
//   1. wb_valid & wb_reg!=0: write wb_reg/wb_data.
//   2. else if q_count!=0: pop the FIFO head and write its reg/data.
//   3. else: ctrl_writeEnable=0; ctrl_writeReg and data_writeReg hold their previous values.
//  Register 0:
//   - a pipeline write to r0 is dropped; that cycle counts as no pipeline write, so a pop may occur;
//   - a multdiv result for r0 is accepted and popped with writeEnable=0.
//  Latency:
//   - pipeline result: 1 cycle (wb at cycle N -> write at N+1);
//   - multdiv result: at least 2 cycles (accepted at N -> earliest pop at N+1 -> write at N+2);
//   - there is no bypass around the FIFO.
//  FIFO: circular buffer with wrap-around pointers; strict FIFO order.
//   - md_ready = (q_count<DEPTH), taken from registered state only;
//   - when full, a pop in the same cycle does not free a slot until the next cycle;
//   - a push and a pop in the same cycle leave q_count unchanged.
//   - the producer holds md_valid/md_reg/md_data stable while md_ready=0.
//  Scoreboard:
//   - md_issue_valid & md_issue_reg!=0 sets busy[md_issue_reg];
//   - a pop clears busy[popped reg] in the cycle the write is registered;
//   - a set and a clear of the same register in the same cycle: set wins.
//  err_flag is set, and stays set until reset, when any of these occurs:
//   - an issue to a register that is already busy;
//   - wb_valid to a busy register with wb_reg!=0 (WAW hazard);
//   - md_valid & md_ready for a register whose busy bit is 0.
//  All state updates on the posedge; no combinational path from inputs to the write port.
// TESTING
//  1. Reset with the FIFO full -> next cycle q_count=0, busy=0, md_ready=1, writeEnable=0, err_flag=0.
//  2. wb r5=0xDEADBEEF at cycle N -> at N+1 writeEnable=1, writeReg=5, data=0xDEADBEEF;
//     wb r0 -> writeEnable=0.
//  3. Issue r7, then md r7=0x12 accepted at cycle N with no wb -> write r7=0x12 at N+2;
//     busy[7]=1 from issue until that write, then 0.
//  4. Continuous wb while md r9=0x34 arrives -> q_count=1 and the wb writes proceed;
//     first idle wb cycle M -> r9 written at M+1.
//  5. Continuous wb with 5 multdiv results (r1..r5) ->
//     - md_ready=0 at q_count=4 and the 5th result is held;
//     - after wb stops, the writes drain in order r1..r5 across the pointer wrap.
//  6. Violations, each from reset:
//     - issue r3 twice -> err_flag=1;
//     - wb r3 while busy[3]=1 -> err_flag=1;
//     - md r4 with busy[4]=0 -> err_flag=1;
//     err_flag stays set until reset.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges in-order pipeline results and FIFO-buffered multdiv
// results onto the single register-file write port, with a pending-result scoreboard.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_data,
  input  logic              md_issue_valid,
  input  logic [4:0]        md_issue_reg,
  input  logic              md_valid,
  input  logic [4:0]        md_reg,
  input  logic [31:0]       md_data,
  output logic              md_ready,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [31:0]       data_writeReg,
  output logic [31:0]       busy,
  output logic [CNT_W-1:0]  q_count,
  output logic              err_flag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             wb_take;
  logic             push;
  logic             pop;
  logic [4:0]       head_reg;
  logic [31:0]      head_data;
  logic [CNT_W-1:0] count_nxt;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic [31:0]      busy_nxt;
  logic             err_nxt;
  logic             we_nxt;
  logic [4:0]       wreg_nxt;
  logic [31:0]      wdata_nxt;

  // Port selection, FIFO bookkeeping, scoreboard and error detection.
  always_comb begin
    wb_take   = wb_valid & (wb_reg != 5'd0);
    push      = md_valid & md_ready;
    pop       = (q_count != '0) & ~wb_take;
    head_reg  = q_reg[rd_ptr];
    head_data = q_data[rd_ptr];

    count_nxt = q_count;
    if (push && !pop)      count_nxt = q_count + CNT_W'(1);
    else if (pop && !push) count_nxt = q_count - CNT_W'(1);

    set_mask = '0;
    if (md_issue_valid && (md_issue_reg != 5'd0)) set_mask = 32'(1) << md_issue_reg;
    clr_mask = '0;
    if (pop) clr_mask = 32'(1) << head_reg;
    // A set and a clear of the same register in one cycle leaves it busy.
    busy_nxt = (busy & ~clr_mask) | set_mask;

    err_nxt = err_flag
            | (md_issue_valid & (md_issue_reg != 5'd0) & busy[md_issue_reg])
            | (wb_take & busy[wb_reg])
            | (push & ~busy[md_reg]);

    we_nxt    = 1'b0;
    wreg_nxt  = ctrl_writeReg;
    wdata_nxt = data_writeReg;
    if (wb_take) begin
      we_nxt    = 1'b1;
      wreg_nxt  = wb_reg;
      wdata_nxt = wb_data;
    end else if (pop) begin
      we_nxt    = (head_reg != 5'd0);
      wreg_nxt  = head_reg;
      wdata_nxt = head_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      q_count          <= '0;
      md_ready         <= 1'b1;
      busy             <= '0;
      err_flag         <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_count          <= count_nxt;
      md_ready         <= (count_nxt < CNT_W'(DEPTH));
      busy             <= busy_nxt;
      err_flag         <= err_nxt;
      ctrl_writeEnable <= we_nxt;
      ctrl_writeReg    <= wreg_nxt;
      data_writeReg    <= wdata_nxt;
    end
  end

  // FIFO storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      q_reg[wr_ptr]  <= md_reg;
      q_data[wr_ptr] <= md_data;
    end
  end

endmodule
